ex_div: RTL and testbench

- Iterative 32-bit radix-2 restoring divider that serves DIV/DIVU in the execute stage.
- EX starts an operation and asserts its stall request while start_i=1 and ready_o=0.
- EX drives ex_hi/ex_lo into the EX/MEM pipeline register from result_o once ready_o=1.
- Supports signed and unsigned division, divide-by-zero, and cancellation by a pipeline flush (annul).

---
 rtl/ex_div_if.sv | 23 ++
 rtl/ex_div.sv | 116 +++++++++++
 tb/tb_ex_div.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// Execute-stage divider handshake: EX drives operands/start/annul,
// the divider returns {remainder, quotient} with a ready flag.
interface ex_div_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per
// clock on magnitudes, sign fix-up applied when the result is registered.
module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  div
);
    localparam int                CW       = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(DATA_W);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    // {partial remainder (DATA_W+1), dividend bits shifting out / quotient shifting in}
    logic [2*DATA_W:0]     work_q;
    logic [2*DATA_W:0]     work_d;
    logic [DATA_W-1:0]     dsor_q;
    logic                  sgn_q;
    logic                  neg1_q;
    logic                  neg2_q;
    logic [2*DATA_W-1:0]   result_q;
    logic                  ready_q;

    logic [DATA_W-1:0]     abs1;
    logic [DATA_W-1:0]     abs2;
    logic [DATA_W+1:0]     trial;
    logic [DATA_W-1:0]     quot;
    logic [DATA_W-1:0]     rem;
    logic [DATA_W-1:0]     quot_fix;
    logic [DATA_W-1:0]     rem_fix;

    always_comb begin
        abs1 = div.opdata1_i;
        abs2 = div.opdata2_i;
        if (div.signed_div_i && div.opdata1_i[DATA_W-1]) abs1 = -div.opdata1_i;
        if (div.signed_div_i && div.opdata2_i[DATA_W-1]) abs2 = -div.opdata2_i;

        // Shift the next dividend bit into the partial remainder and try the subtract.
        trial  = {work_q[2*DATA_W:DATA_W], work_q[DATA_W-1]} - {2'b00, dsor_q};
        work_d = {work_q[2*DATA_W-1:0], 1'b0};
        if (!trial[DATA_W+1])
            work_d = {trial[DATA_W:0], work_q[DATA_W-2:0], 1'b1};

        quot     = work_q[DATA_W-1:0];
        rem      = work_q[2*DATA_W-1:DATA_W];
        quot_fix = (sgn_q && (neg1_q ^ neg2_q)) ? -quot : quot;
        rem_fix  = (sgn_q && neg1_q) ? -rem : rem;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            work_q   <= '0;
            dsor_q   <= '0;
            sgn_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
                    if (div.start_i && !div.annul_i) begin
                        sgn_q  <= div.signed_div_i;
                        neg1_q <= div.signed_div_i & div.opdata1_i[DATA_W-1];
                        neg2_q <= div.signed_div_i & div.opdata2_i[DATA_W-1];
                        cnt_q  <= '0;
                        if (div.opdata2_i == '0) begin
                            state_q <= BYZERO;
                        end else begin
                            work_q  <= {{(DATA_W+1){1'b0}}, abs1};
                            dsor_q  <= abs2;
                            state_q <= ON;
                        end
                    end
                end
                BYZERO: begin
                    result_q <= '0;
                    ready_q  <= 1'b1;
                    state_q  <= END;
                end
                ON: begin
                    if (div.annul_i) begin
                        cnt_q   <= '0;
                        state_q <= FREE;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q <= {rem_fix, quot_fix};
                        ready_q  <= 1'b1;
                        state_q  <= END;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 1'b1;
                    end
                end
                END: begin
                    // Held while EX keeps start high (downstream stall).
                    if (!div.start_i) begin
                        ready_q  <= 1'b0;
                        result_q <= '0;
                        state_q  <= FREE;
                    end
                end
                default: state_q <= FREE;
            endcase
        end
    end

    assign div.result_o = result_q;
    assign div.ready_o  = ready_q;
endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, signed/unsigned results, divide-by-zero,
// annul, async reset, result hold under stall.
module tb_ex_div;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    ex_div_if #(.DATA_W(32)) dif ();
    ex_div #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .div(dif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, measure edges from the accepting edge to ready_o,
    // optionally disturb operands mid-flight and hold start after completion.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input int hold,
                          input bit scramble, input string tag);
        int n;
        @(negedge clk);
        dif.signed_div_i = sgn;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!dif.ready_o && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (scramble && n == 5) begin
                dif.opdata1_i    = 32'hDEADBEEF;
                dif.opdata2_i    = 32'h0;
                dif.signed_div_i = ~sgn;
            end
        end
        chk({tag, " latency"}, 65'(n), 65'(lat));
        chk({tag, " result"}, {1'b0, dif.result_o}, {1'b0, exp});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (i == 1) dif.annul_i = 1'b1;
            chk({tag, " hold"}, {dif.ready_o, dif.result_o}, {1'b1, exp});
        end
        dif.annul_i = 1'b0;
        dif.start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, " drop"}, {dif.ready_o, dif.result_o}, 65'h0);
    endtask

    initial begin
        int  n;
        logic seen;
        rst              = 1'b0;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        #12;
        chk("reset", {dif.ready_o, dif.result_o}, 65'h0);
        @(negedge clk) rst = 1'b1;

        run_op(1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33, 0, 1'b0, "u100/7");
        run_op(1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 33, 0, 1'b0, "s-7/2");
        run_op(1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33, 0, 1'b0, "s7/-2");
        run_op(1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33, 0, 1'b0, "smin/-1");
        run_op(1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 33, 0, 1'b0, "umax/1");
        run_op(1'b0, 32'hFFFFFFF9,  32'd2,         64'h00000001_7FFFFFFC, 33, 0, 1'b0, "uFFF9/2");
        run_op(1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 33, 0, 1'b0, "s-100/-7");
        run_op(1'b0, 32'd5,         32'd0,         64'h0,                  1, 0, 1'b0, "div0");
        run_op(1'b1, 32'hFFFFFF9C,  32'd7,         64'hFFFFFFFE_FFFFFFF2, 33, 5, 1'b1, "stall+scramble");

        // Annul at edge 10 of an in-flight operation.
        @(negedge clk);
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd100;
        dif.opdata2_i    = 32'd7;
        dif.start_i      = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk) dif.annul_i = 1'b1;
        @(posedge clk); #1;
        chk("annul edge", {64'h0, dif.ready_o}, 65'h0);
        @(negedge clk);
        dif.annul_i = 1'b0;
        dif.start_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | dif.ready_o;
        end
        chk("annul no ready", {64'h0, seen}, 65'h0);
        run_op(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0, 1'b0, "after annul 9/3");

        // start with annul in FREE is rejected; acceptance slips one edge.
        @(negedge clk);
        dif.opdata1_i = 32'd100;
        dif.opdata2_i = 32'd7;
        dif.start_i   = 1'b1;
        dif.annul_i   = 1'b1;
        @(posedge clk); #1;
        dif.annul_i = 1'b0;
        n = 0;
        while (!dif.ready_o && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("free annul latency", 65'(n), 65'd34);
        chk("free annul result", {1'b0, dif.result_o}, {1'b0, 64'h00000002_0000000E});
        dif.start_i = 1'b0;
        @(posedge clk); #1;

        // Async reset mid-ON at edge 15.
        @(negedge clk);
        dif.opdata1_i = 32'd100;
        dif.opdata2_i = 32'd7;
        dif.start_i   = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("rst mid-ON", {dif.ready_o, dif.result_o}, 65'h0);
        @(negedge clk) dif.start_i = 1'b0;
        @(negedge clk) rst = 1'b1;
        run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0, 1'b0, "after rst 100/7");

        // Async reset while a result is being held.
        @(negedge clk);
        dif.opdata1_i = 32'd9;
        dif.opdata2_i = 32'd2;
        dif.start_i   = 1'b1;
        n = 0;
        while (!dif.ready_o && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre-rst END", {dif.ready_o, dif.result_o}, {1'b1, 64'h00000001_00000004});
        #2 rst = 1'b0;
        #1 chk("rst in END", {dif.ready_o, dif.result_o}, 65'h0);
        @(negedge clk) dif.start_i = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("idle after rst", {dif.ready_o, dif.result_o}, 65'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
